// File: rtl/store_commit_buffer.sv
// store_commit_buffer
// Holds executed stores in program order until the reorder buffer commits them,
// then drains committed stores to data memory over a valid/ready write port.
// Loads look up the queue combinationally and take the youngest matching store.
//
//  state | meaning
//  IDLE  | no write outstanding; waiting for a committed entry at head
//  WRITE | mem_we asserted with head entry; waiting for mem_ready
module store_commit_buffer #(
    parameter int WORD_SIZE = 32,
    parameter int RB_INDEX  = 4,
    parameter int DEPTH     = 4,
    parameter int PTR_W     = 2,
    parameter logic [RB_INDEX-1:0] NULL_IDX = {RB_INDEX{1'b1}}
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 st_valid,
    input  logic [WORD_SIZE-1:0] st_addr,
    input  logic [WORD_SIZE-1:0] st_data,
    input  logic [RB_INDEX-1:0]  st_rb_index,
    output logic                 full,
    output logic [PTR_W:0]       count,
    output logic                 overflow,
    input  logic                 commit_valid,
    input  logic [RB_INDEX-1:0]  commit_rb_index,
    input  logic                 flush,
    output logic                 mem_we,
    output logic [WORD_SIZE-1:0] mem_addr,
    output logic [WORD_SIZE-1:0] mem_wdata,
    input  logic                 mem_ready,
    input  logic [WORD_SIZE-1:0] ld_addr,
    output logic                 ld_hit,
    output logic [WORD_SIZE-1:0] ld_data
);

    typedef enum logic {IDLE, WRITE} state_t;

    state_t               state;
    logic [DEPTH-1:0]     vld;
    logic [DEPTH-1:0]     cmt;
    logic [WORD_SIZE-1:0] e_addr [DEPTH];
    logic [WORD_SIZE-1:0] e_data [DEPTH];
    logic [RB_INDEX-1:0]  e_rbi  [DEPTH];
    logic [PTR_W-1:0]     head;
    logic [PTR_W-1:0]     tail;
    logic [PTR_W:0]       count_q;

    logic                 push;
    logic                 pop;
    logic                 push_cmt;
    logic [PTR_W-1:0]     head_nx;
    logic [DEPTH-1:0]     cmt_upd;
    logic [PTR_W:0]       cmt_cnt;
    logic [PTR_W-1:0]     fwd_idx;

    assign full     = (count_q == (PTR_W+1)'(DEPTH));
    assign count    = count_q;
    assign push     = st_valid && !full && (st_rb_index != NULL_IDX) && !flush;
    assign pop      = (state == WRITE) && mem_ready;
    assign push_cmt = commit_valid && (st_rb_index == commit_rb_index);
    assign head_nx  = head + PTR_W'(1);

    // Commit marks applied this cycle, and how many valid entries end up committed
    always_comb begin
        cmt_upd = cmt;
        cmt_cnt = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (commit_valid && vld[i] && (e_rbi[i] == commit_rb_index))
                cmt_upd[i] = 1'b1;
            if (vld[i] && cmt_upd[i])
                cmt_cnt = cmt_cnt + (PTR_W+1)'(1);
        end
    end

    // Forwarding lookup: walk oldest to youngest so the youngest match wins
    always_comb begin
        ld_hit  = 1'b0;
        ld_data = '0;
        fwd_idx = head;
        for (int i = 0; i < DEPTH; i++) begin
            fwd_idx = head + PTR_W'(i);
            if (vld[fwd_idx] && (e_addr[fwd_idx] == ld_addr)) begin
                ld_hit  = 1'b1;
                ld_data = e_data[fwd_idx];
            end
        end
    end

    // Queue storage, pointers, occupancy and sticky overflow
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            vld      <= '0;
            cmt      <= '0;
            head     <= '0;
            tail     <= '0;
            count_q  <= '0;
            overflow <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                e_addr[i] <= '0;
                e_data[i] <= '0;
                e_rbi[i]  <= '0;
            end
        end else begin
            if (st_valid && full)
                overflow <= 1'b1;

            cmt <= cmt_upd & vld;

            if (push) begin
                e_addr[tail] <= st_addr;
                e_data[tail] <= st_data;
                e_rbi[tail]  <= st_rb_index;
                vld[tail]    <= 1'b1;
                cmt[tail]    <= push_cmt;
                tail         <= tail + PTR_W'(1);
            end

            // Committed entries are a prefix from head, so they survive a flush
            if (flush) begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (!cmt_upd[i]) begin
                        vld[i] <= 1'b0;
                        cmt[i] <= 1'b0;
                    end
                end
                tail <= head + cmt_cnt[PTR_W-1:0];
            end

            if (pop) begin
                vld[head] <= 1'b0;
                cmt[head] <= 1'b0;
                head      <= head_nx;
            end

            if (flush)
                count_q <= cmt_cnt - {{PTR_W{1'b0}}, pop};
            else
                count_q <= count_q + {{PTR_W{1'b0}}, push} - {{PTR_W{1'b0}}, pop};
        end
    end

    // Drain FSM with registered write request; FSM looks at registered commit state
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state     <= IDLE;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (vld[head] && cmt[head]) begin
                        mem_we    <= 1'b1;
                        mem_addr  <= e_addr[head];
                        mem_wdata <= e_data[head];
                        state     <= WRITE;
                    end
                end
                WRITE: begin
                    if (mem_ready) begin
                        if (vld[head_nx] && cmt[head_nx]) begin
                            mem_addr  <= e_addr[head_nx];
                            mem_wdata <= e_data[head_nx];
                        end else begin
                            mem_we <= 1'b0;
                            state  <= IDLE;
                        end
                    end
                end
                default: begin
                    mem_we <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_store_commit_buffer.sv
// Testbench for store_commit_buffer: directed scenarios plus randomized traffic,
// all checked against a queue-based model of the store buffer.
module tb_store_commit_buffer;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        st_valid;
    logic [31:0] st_addr;
    logic [31:0] st_data;
    logic [3:0]  st_rb_index;
    logic        full;
    logic [2:0]  count;
    logic        overflow;
    logic        commit_valid;
    logic [3:0]  commit_rb_index;
    logic        flush;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ready;
    logic [31:0] ld_addr;
    logic        ld_hit;
    logic [31:0] ld_data;

    always #5 clk = ~clk;

    store_commit_buffer dut (
        .clk(clk), .reset_n(reset_n),
        .st_valid(st_valid), .st_addr(st_addr), .st_data(st_data), .st_rb_index(st_rb_index),
        .full(full), .count(count), .overflow(overflow),
        .commit_valid(commit_valid), .commit_rb_index(commit_rb_index), .flush(flush),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ready(mem_ready),
        .ld_addr(ld_addr), .ld_hit(ld_hit), .ld_data(ld_data)
    );

    typedef struct {
        logic [31:0] a;
        logic [31:0] d;
        logic [3:0]  r;
        bit          c;
    } ent_t;

    ent_t        q[$];
    bit          m_we;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    bit          m_ovf;
    int          rb_ctr;
    int          checks = 0;
    int          errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One clock edge of the reference behaviour, using the inputs held across the edge
    task automatic model_step();
        bit full_m;
        bit pop_m;
        if (!reset_n) begin
            q.delete();
            m_we = 0; m_addr = '0; m_wdata = '0; m_ovf = 0;
            return;
        end
        full_m = (q.size() == 4);
        if (st_valid && full_m) m_ovf = 1;
        pop_m = m_we && mem_ready;
        if (m_we) begin
            if (mem_ready) begin
                if (q.size() > 1 && q[1].c) begin
                    m_addr = q[1].a; m_wdata = q[1].d;
                end else begin
                    m_we = 0;
                end
            end
        end else if (q.size() > 0 && q[0].c) begin
            m_we = 1; m_addr = q[0].a; m_wdata = q[0].d;
        end
        if (commit_valid)
            foreach (q[i]) if (q[i].r == commit_rb_index) q[i].c = 1;
        if (st_valid && !full_m && st_rb_index != 4'hf && !flush) begin
            q.push_back('{st_addr, st_data, st_rb_index,
                          (commit_valid && st_rb_index == commit_rb_index)});
            rb_ctr = (rb_ctr + 1) % 15;
        end
        if (flush)
            while (q.size() > 0 && !q[q.size()-1].c) void'(q.pop_back());
        if (pop_m) void'(q.pop_front());
    endtask

    task automatic check_all();
        bit          eh;
        logic [31:0] ed;
        chk("mem_we",    {31'd0, mem_we},   {31'd0, m_we});
        chk("mem_addr",  mem_addr,          m_addr);
        chk("mem_wdata", mem_wdata,         m_wdata);
        chk("count",     {29'd0, count},    q.size());
        chk("full",      {31'd0, full},     {31'd0, q.size() == 4});
        chk("overflow",  {31'd0, overflow}, {31'd0, m_ovf});
        eh = 0; ed = '0;
        foreach (q[i]) if (q[i].a == ld_addr) begin eh = 1; ed = q[i].d; end
        chk("ld_hit",  {31'd0, ld_hit}, {31'd0, eh});
        chk("ld_data", ld_data, ed);
    endtask

    task automatic step();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_all();
    endtask

    task automatic quiet();
        st_valid = 0; commit_valid = 0; flush = 0;
    endtask

    task automatic push(input logic [31:0] a, input logic [31:0] d, input logic [3:0] r);
        st_valid = 1; st_addr = a; st_data = d; st_rb_index = r;
        step();
        st_valid = 0;
    endtask

    task automatic commit(input logic [3:0] r);
        commit_valid = 1; commit_rb_index = r;
        step();
        commit_valid = 0;
    endtask

    task automatic do_reset();
        quiet();
        reset_n = 0;
        step();
        reset_n = 1;
    endtask

    task automatic drive_random();
        int fu;
        int r;
        reset_n     = ($urandom_range(0, 299) != 0);
        st_valid    = $urandom_range(0, 1);
        st_rb_index = ($urandom_range(0, 15) == 0) ? 4'hf : 4'(rb_ctr);
        st_addr     = 32'h40 + 32'(4 * $urandom_range(0, 3));
        st_data     = $urandom;
        fu = -1;
        foreach (q[i]) if (fu < 0 && !q[i].c) fu = i;
        r = $urandom_range(0, 9);
        commit_valid = 0;
        commit_rb_index = 4'(r);
        if (fu >= 0 && r < 5) begin
            commit_valid = 1; commit_rb_index = q[fu].r;
        end else if (fu < 0 && r < 5 && st_valid) begin
            commit_valid = 1; commit_rb_index = st_rb_index;
        end else if (r == 9) begin
            commit_valid = 1; commit_rb_index = 4'hf;
        end
        flush     = ($urandom_range(0, 19) == 0);
        mem_ready = ($urandom_range(0, 3) != 0);
        ld_addr   = 32'h40 + 32'(4 * $urandom_range(0, 4));
    endtask

    initial begin
        rb_ctr = 0;
        m_we = 0; m_addr = '0; m_wdata = '0; m_ovf = 0;
        // 1: reset with junk on the inputs
        reset_n = 0; st_valid = 1; st_addr = 32'h100; st_data = 32'hdead;
        st_rb_index = 4'h3; commit_valid = 1; commit_rb_index = 4'h3;
        flush = 1; mem_ready = 1; ld_addr = 32'h100;
        @(negedge clk);
        step();
        chk("rst_we",  {31'd0, mem_we}, 32'd0);
        chk("rst_hit", {31'd0, ld_hit}, 32'd0);
        reset_n = 1;
        quiet();

        // 2: single store, commit, one-cycle write
        push(32'h100, 32'haa, 4'h3);
        commit(4'h3);
        step();
        chk("t2_we",   {31'd0, mem_we}, 32'd1);
        chk("t2_addr", mem_addr, 32'h100);
        step();
        chk("t2_done", {31'd0, mem_we}, 32'd0);
        step();

        // 3: fill, drop one while full, then back-to-back drain
        for (int i = 1; i <= 5; i++) push(32'h200 + 32'(i * 4), 32'(i), 4'(i));
        chk("t3_full", {31'd0, full}, 32'd1);
        chk("t3_ovf",  {31'd0, overflow}, 32'd1);
        for (int i = 1; i <= 4; i++) commit(4'(i));
        for (int i = 0; i < 4; i++) step();

        // 4: flush keeps only committed prefix
        do_reset();
        for (int i = 1; i <= 3; i++) push(32'h300 + 32'(i * 4), 32'(i + 16), 4'(i));
        mem_ready = 0;
        commit(4'h1);
        flush = 1; step(); flush = 0;
        chk("t4_cnt", {29'd0, count}, 32'd1);
        commit(4'h2);
        mem_ready = 1;
        for (int i = 0; i < 3; i++) step();
        chk("t4_cnt0", {29'd0, count}, 32'd0);

        // 5: youngest-match forwarding
        do_reset();
        push(32'h40, 32'd1, 4'h7);
        push(32'h40, 32'd2, 4'h8);
        ld_addr = 32'h40; #1;
        chk("t5_hit",  {31'd0, ld_hit}, 32'd1);
        chk("t5_data", ld_data, 32'd2);
        ld_addr = 32'h44; #1;
        chk("t5_miss", {31'd0, ld_hit}, 32'd0);
        chk("t5_zero", ld_data, 32'd0);

        // 6: write held under back-pressure, then reset mid-write
        do_reset();
        mem_ready = 0;
        push(32'h500, 32'h55, 4'h2);
        commit(4'h2);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("t6_hold_we",   {31'd0, mem_we}, 32'd1);
            chk("t6_hold_addr", mem_addr, 32'h500);
            chk("t6_hold_data", mem_wdata, 32'h55);
        end
        reset_n = 0; step(); reset_n = 1;
        chk("t6_rst_we", {31'd0, mem_we}, 32'd0);

        // Randomized traffic
        do_reset();
        rb_ctr = 0;
        for (int n = 0; n < 3000; n++) begin
            drive_random();
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
